// File: rtl/aclk_ctrl_fsm_if.sv
// Keypad/button inputs and display/strobe outputs of the alarm clock key-entry controller.
interface aclk_ctrl_fsm_if;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       one_second;
  logic       shift;
  logic       show_new_time;
  logic       show_a;
  logic       load_new_a;
  logic       load_new_c;
  logic [2:0] digits_entered;

  modport master (
    output key, alarm_button, time_button, one_second,
    input  shift, show_new_time, show_a, load_new_a, load_new_c, digits_entered
  );

  modport slave (
    input  key, alarm_button, time_button, one_second,
    output shift, show_new_time, show_a, load_new_a, load_new_c, digits_entered
  );
endinterface

// File: rtl/aclk_ctrl_fsm.sv
// Key-entry control FSM for the alarm clock: shift strobes, display select,
// load strobes for alarm/clock and an inactivity timeout back to time display.
module aclk_ctrl_fsm #(
  parameter int         TIMEOUT_SEC = 10,
  parameter logic [3:0] NOKEY       = 4'hA
) (
  input  logic            clk,
  input  logic            reset,
  aclk_ctrl_fsm_if.slave  bus
);

  localparam int            CW       = $clog2(TIMEOUT_SEC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_SEC - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_SEC);

  typedef enum logic [2:0] {
    SHOW_TIME, SHOW_ALARM, KEY_STORED, KEY_WAITED,
    KEY_ENTRY, LOAD_TIME, LOAD_ALARM, WAIT_REL
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [2:0]    digits;
  logic          key_valid;
  logic          timeout;

  // Digit codes sit below NOKEY; NOKEY and everything above read as "no key".
  assign key_valid = (bus.key < NOKEY);
  // >= keeps the timeout reachable if the counter stepped past the last value on a release cycle.
  assign timeout   = bus.one_second && (cnt >= CNT_LAST);
  assign bus.digits_entered = digits;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= SHOW_TIME;
      cnt    <= '0;
      digits <= '0;
    end else begin
      state <= state_next;
      if (state_next == SHOW_TIME || state_next == KEY_STORED)
        cnt <= '0;
      else if ((state == KEY_WAITED || state == KEY_ENTRY) && bus.one_second && cnt < CNT_MAX)
        cnt <= cnt + 1'b1;
      if (state == SHOW_TIME && state_next == KEY_STORED)
        digits <= '0;
      else if (state == KEY_STORED && digits != 3'd4)
        digits <= digits + 3'd1;
    end
  end

  always_comb begin
    state_next        = state;
    bus.shift         = 1'b0;
    bus.show_new_time = 1'b0;
    bus.show_a        = 1'b0;
    bus.load_new_a    = 1'b0;
    bus.load_new_c    = 1'b0;
    case (state)
      SHOW_TIME: begin
        if (key_valid)             state_next = KEY_STORED;
        else if (bus.alarm_button) state_next = SHOW_ALARM;
      end
      SHOW_ALARM: begin
        bus.show_a = 1'b1;
        if (!bus.alarm_button) state_next = SHOW_TIME;
      end
      KEY_STORED: begin
        bus.shift         = 1'b1;
        bus.show_new_time = 1'b1;
        state_next        = KEY_WAITED;
      end
      KEY_WAITED: begin
        bus.show_new_time = 1'b1;
        if (!key_valid)   state_next = KEY_ENTRY;
        else if (timeout) state_next = SHOW_TIME;
      end
      KEY_ENTRY: begin
        bus.show_new_time = 1'b1;
        if (key_valid)                                  state_next = KEY_STORED;
        else if (bus.time_button && digits == 3'd4)     state_next = LOAD_TIME;
        else if (bus.alarm_button && digits == 3'd4)    state_next = LOAD_ALARM;
        else if (timeout)                               state_next = SHOW_TIME;
      end
      LOAD_TIME: begin
        bus.load_new_c = 1'b1;
        state_next     = SHOW_TIME;
      end
      LOAD_ALARM: begin
        bus.load_new_a = 1'b1;
        state_next     = WAIT_REL;
      end
      // Hold here until ALARM is released so the committing press does not show the alarm.
      WAIT_REL: begin
        if (!bus.alarm_button) state_next = SHOW_TIME;
      end
      default: state_next = SHOW_TIME;
    endcase
  end

endmodule

// File: doc/aclk_ctrl_fsm.md
Name: aclk_ctrl_fsm

Overview:
- Control FSM for the alarm clock key-entry path.
- Watches the keypad code and the ALARM/TIME buttons, and generates the one-cycle shift strobe that pushes each pressed digit into the 4-digit key buffer register.
- Decides which display source is shown: current time, alarm time or digits being entered.
- Issues one-cycle load strobes that commit the buffered digits to the alarm register or the clock counter.
- Inactivity timeout returns the clock to normal time display.

Parameters:
- TIMEOUT_SEC, 10, number of one_second pulses without a key press before abandoning entry
- NOKEY, 4'hA, key code meaning "no key pressed"; codes 0-9 are digits, 11-15 are treated as NOKEY

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- key  input  4  keypad code, held for the duration of a press
- alarm_button  input  1  level, high while ALARM pressed
- time_button  input  1  level, high while TIME pressed
- one_second  input  1  one-cycle pulse, once per second
- shift  output  1  one-cycle strobe to the key buffer register, shift in key
- show_new_time  output  1  display the key buffer contents
- show_a  output  1  display the stored alarm time
- load_new_a  output  1  one-cycle strobe, key buffer -> alarm register
- load_new_c  output  1  one-cycle strobe, key buffer -> clock counter
- digits_entered  output  3  digits shifted since entry began, saturates at 4

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on posedge clk.
  - reset is synchronous, active-high, and has priority over everything else.
  - Reset -> state SHOW_TIME, timeout counter 0, digits_entered 0, all strobes/display outputs 0.
  - Reset mid-entry discards the entry; no load strobe is issued.
- Output encoding:
  - All outputs are Moore, decoded from registered state.
  - digits_entered is a register.
- States and transitions, evaluated in the listed priority order:
  - SHOW_TIME (all outputs 0):
    - key valid -> KEY_STORED, digits_entered <= 0.
    - else alarm_button -> SHOW_ALARM.
  - SHOW_ALARM (show_a=1):
    - alarm_button low -> SHOW_TIME.
    - key input is ignored.
  - KEY_STORED (shift=1, show_new_time=1; exactly one cycle):
    - digits_entered <= min(digits_entered+1, 4).
    - Timeout counter <= 0.
    - -> KEY_WAITED.
  - KEY_WAITED (show_new_time=1), waits for key release:
    - key == NOKEY -> KEY_ENTRY.
    - else timeout -> SHOW_TIME.
    - A held key never produces a second shift.
  - KEY_ENTRY (show_new_time=1):
    - key valid -> KEY_STORED.
    - else time_button and digits_entered==4 -> LOAD_TIME.
    - else alarm_button and digits_entered==4 -> LOAD_ALARM.
    - else timeout -> SHOW_TIME.
    - Buttons with fewer than 4 digits are ignored; the FSM stays in KEY_ENTRY.
    - time_button wins over alarm_button when both are high.
  - LOAD_TIME (load_new_c=1; one cycle) -> SHOW_TIME.
  - LOAD_ALARM (load_new_a=1; one cycle) -> WAIT_REL.
  - WAIT_REL (all 0):
    - alarm_button low -> SHOW_TIME.
    - Prevents falling into SHOW_ALARM on the same press.
- Timeout counter:
  - Width $clog2(TIMEOUT_SEC+1).
  - Increments on one_second only in KEY_WAITED/KEY_ENTRY.
  - "timeout" = one_second high while counter == TIMEOUT_SEC-1.
  - Cleared on entry to KEY_STORED, SHOW_TIME and on reset; never wraps.
  - A key press in the same cycle as the timeout pulse wins; entry continues.
- Fifth and later digits:
  - Still shift; the buffer keeps the last 4.
  - digits_entered stays 4.
- Strobes: shift, load_new_a and load_new_c are mutually exclusive and never high for two consecutive cycles.

Test Plan:
1. Reset then key=3 for 5 cycles, then NOKEY -> shift high exactly 1 cycle (cycle after key seen), digits_entered=1, show_new_time=1, state KEY_ENTRY.
2. Enter 1,2,3,0, then time_button pulse -> 4 shift pulses, digits_entered=4, load_new_c high 1 cycle, then all outputs 0 (SHOW_TIME).
3. Enter 0,7 (2 digits), press alarm_button -> no load_new_a; after 10 one_second pulses with no key -> show_new_time drops to 0, digits_entered unchanged until next entry.
4. Enter 4 digits, hold alarm_button 20 cycles -> load_new_a 1 cycle, show_a stays 0 while held; after release, press again -> show_a=1 while held.
5. In KEY_ENTRY, key=5 arrives in the same cycle as the 10th one_second pulse -> shift asserted, timeout counter restarts at 0, no return to SHOW_TIME.
6. Assert reset during KEY_WAITED with key held -> next cycle all outputs 0, digits_entered=0; key still held after reset -> a new entry starts with one shift.
